calc_display: RTL and testbench
===============================

Name: calc_display

Overview:
- Receiving end of the calculator's result stream. Consumes the serial digit interface (status/data/pos) and drives an 8-digit multiplexed seven-segment display.
- Captures digits into a shadow buffer while the calculator is busy. Commits the whole frame atomically when the calculator returns to ready, then scans the committed frame onto the display with a refresh prescaler.
- Sits between the calculator core and the board pins.

Parameters:
REFRESH_DIV, 100000, clock cycles each digit stays lit (>=2; benches use 4)
BLANK_LZ, 1, 1 = blank leading zeros above the most significant non-zero digit; 0 = show all 8 digits

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
in_status  in  2  calculator status: 00 error, 01 busy, 10 ready, 11 ignored
in_data  in  4  BCD digit value for position in_pos
in_pos  in  4  digit index, 0 = least significant; values 8..15 are not digit writes
an  out  8  anode enables, active-low, one-hot-zero
seg  out  8  {dp,g,f,e,d,c,b,a}, active-low
err  out  1  sticky error indicator

Behaviour:
- Reset (async): shadow[0..7]=0, frame[0..7]=0, err=0, scan_idx=0, prescaler=0, an=8'hFF, seg=8'hFF, prev_status=01.
- Capture: on each posedge where in_status==01 and in_pos<=7, shadow[in_pos] <= in_data.
  - in_pos 8..15 is ignored.
  - Repeated writes to the same position: the last one wins.
- Commit: the frame is copied when prev_status==01 and in_status==10 (busy->ready edge).
  - frame <= shadow on that clock, with the write from that same cycle excluded (status is not 01).
  - shadow is retained, not cleared.
  - Ready->ready produces no commit. Ready->busy->ready produces exactly one commit.
- prev_status <= in_status every cycle.
- Error handling:
  - in_status==00 on any posedge sets err=1 (sticky until reset).
  - While err=1, capture and commit are disabled, and the display shows "E","r","r" on digits 2,1,0 with digits 7..3 blank.
  - If error and commit qualify in the same cycle, error wins and no commit happens.
- Leading-zero blanking (BLANK_LZ=1): digit k is blank if frame[j]==0 for all j>=k and k!=0. Digit 0 is always shown.
- Decode: 0-9 use standard segments. Values 10-15 in frame decode to blank (seg=8'hFF). dp is always off (1).
- Scan:
  - prescaler counts 0..REFRESH_DIV-1.
  - At terminal count, prescaler returns to 0 and scan_idx <= (scan_idx+1) mod 8 (wraps 7->0).
- Outputs: an and seg are both registered from the same scan_idx in the same cycle, so a digit change never shows a stale pattern.
  - an = ~(8'b1 << scan_idx).
  - The first lit output appears 1 cycle after reset release (an=8'hFE).
- Latency: a committed value appears on seg at the next register update whose scan_idx selects that digit, no later than 8*REFRESH_DIV+1 cycles after commit.
- Reset mid-frame: all state returns to reset values immediately. The partial shadow is discarded.
- in_status==11 counts as neither busy nor ready: no capture, no commit, but prev_status is updated.

Decomposition:
- calc_pkg (shared):
  - status localparams ST_ERR=2'b00, ST_BUSY=2'b01, ST_READY=2'b10.
  - Seven-segment constants SEG_BLANK, SEG_E, SEG_R.
  - Digit-count constant N_DIGITS=8.
- Sub-module seg7_decode: combinational 4-bit value plus blank flag -> 8-bit active-low pattern. Shared with any future display block.
- calc_display holds the capture/commit registers, error flag, blanking logic, prescaler and scan counter.

Test Plan:
- Frame 1234: reset; status=01, write pos0..7 = 4,3,2,1,0,0,0,0; status=10 -> across one scan, digit0..3 show 4,3,2,1 (seg 8'h99,8'hB0,8'hA4,8'hF9) and digits 4..7 are blank (8'hFF).
- No commit without edge: hold status=10 and toggle in_pos/in_data -> the displayed frame is unchanged. Then status=01, write pos0=7, status=10 -> digit0 shows 7 (8'hF8) and other digits keep their previous values.
- Zero and BLANK_LZ: commit all zeros -> only digit0 shows 0 (8'hC0). With BLANK_LZ=0 all 8 digits show 8'hC0.
- Error: mid-capture drive status=00 for 1 cycle, then 01/10 -> err=1, display shows Err (digit2 8'h86, digit1 8'hAF, digit0 8'hAF) and no further commit. Reset clears err.
- Scan timing (REFRESH_DIV=4): an sequence FE,FD,FB,...,7F,FE with each value held exactly 4 cycles. an and seg change on the same edge.
- Async reset mid-scan: assert reset between edges -> an=8'hFF and seg=8'hFF immediately. After release, an=8'hFE on the first edge with digit0 showing 0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants for the calculator result path:
// status codes, seven-segment glyphs and digit count.
package calc_pkg;

  localparam logic [1:0] ST_ERR   = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;

  localparam int N_DIGITS = 8;

  // {dp,g,f,e,d,c,b,a}, active-low
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_R     = 8'hAF;

endpackage

// File: rtl/seg7_decode.sv
// BCD value to active-low seven-segment pattern.
// Non-decimal values and the blank request both give an unlit digit.
module seg7_decode
  import calc_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (value)
        4'd0:    seg = 8'hC0;
        4'd1:    seg = 8'hF9;
        4'd2:    seg = 8'hA4;
        4'd3:    seg = 8'hB0;
        4'd4:    seg = 8'h99;
        4'd5:    seg = 8'h92;
        4'd6:    seg = 8'h82;
        4'd7:    seg = 8'hF8;
        4'd8:    seg = 8'h80;
        4'd9:    seg = 8'h90;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/calc_display.sv
// Captures the calculator digit stream into a shadow buffer,
// commits it on busy->ready and scans it onto an 8-digit display.
module calc_display
  import calc_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] in_status,
  input  logic [3:0] in_data,
  input  logic [3:0] in_pos,
  output logic [7:0] an,
  output logic [7:0] seg,
  output logic       err
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  logic [3:0]    shadow_q [N_DIGITS];
  logic [3:0]    shadow_d [N_DIGITS];
  logic [3:0]    frame_q  [N_DIGITS];
  logic [3:0]    frame_d  [N_DIGITS];
  logic          err_q, err_d;
  logic [1:0]    prev_status_q, prev_status_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    scan_idx_q, scan_idx_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;

  logic          capture;
  logic          commit;
  logic          nz_acc;
  logic [N_DIGITS-1:0] nz_above;
  logic          lz_blank;
  logic [7:0]    dec_seg;

  // An error status this cycle already locks out capture and commit
  always_comb begin
    err_d   = err_q | (in_status == ST_ERR);
    capture = !err_d && (in_status == ST_BUSY) && !in_pos[3];
    commit  = !err_d && (prev_status_q == ST_BUSY)
              && (in_status == ST_READY);
    prev_status_d = in_status;
    for (int k = 0; k < N_DIGITS; k++) begin
      shadow_d[k] = shadow_q[k];
      frame_d[k]  = commit ? shadow_q[k] : frame_q[k];
    end
    if (capture) shadow_d[in_pos[2:0]] = in_data;
  end

  always_comb begin
    presc_d    = presc_q + PW'(1);
    scan_idx_d = scan_idx_q;
    if (presc_q == PRESC_LAST) begin
      presc_d    = '0;
      scan_idx_d = scan_idx_q + 3'd1;
    end
  end

  // nz_above[k]: some digit at k or above is non-zero
  always_comb begin
    nz_acc   = 1'b0;
    nz_above = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      nz_acc      = nz_acc | (frame_q[k] != 4'd0);
      nz_above[k] = nz_acc;
    end
    lz_blank = BLANK_LZ && (scan_idx_q != 3'd0)
               && !nz_above[scan_idx_q];
  end

  seg7_decode u_dec (
    .value (frame_q[scan_idx_q]),
    .blank (lz_blank),
    .seg   (dec_seg)
  );

  always_comb begin
    an_d  = ~(8'd1 << scan_idx_q);
    seg_d = dec_seg;
    if (err_q) begin
      case (scan_idx_q)
        3'd2:       seg_d = SEG_E;
        3'd1, 3'd0: seg_d = SEG_R;
        default:    seg_d = SEG_BLANK;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_q      <= '{default: '0};
      frame_q       <= '{default: '0};
      err_q         <= 1'b0;
      prev_status_q <= ST_BUSY;
      presc_q       <= '0;
      scan_idx_q    <= '0;
      an_q          <= 8'hFF;
      seg_q         <= SEG_BLANK;
    end else begin
      shadow_q      <= shadow_d;
      frame_q       <= frame_d;
      err_q         <= err_d;
      prev_status_q <= prev_status_d;
      presc_q       <= presc_d;
      scan_idx_q    <= scan_idx_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign err = err_q;

endmodule

// File: tb/tb_calc_display.sv
// Randomized scoreboard bench for calc_display, two blanking variants
// side by side against a frame-level reference model.
module tb_calc_display;

  localparam int RDIV = 4;

  logic       clock;
  logic       reset;
  logic [1:0] in_status;
  logic [3:0] in_data;
  logic [3:0] in_pos;
  logic [7:0] an1, seg1, an0, seg0;
  logic       err1, err0;

  calc_display #(.REFRESH_DIV(RDIV), .BLANK_LZ(1'b1)) u_dut (
    .clock(clock), .reset(reset), .in_status(in_status),
    .in_data(in_data), .in_pos(in_pos),
    .an(an1), .seg(seg1), .err(err1)
  );

  calc_display #(.REFRESH_DIV(RDIV), .BLANK_LZ(1'b0)) u_dut0 (
    .clock(clock), .reset(reset), .in_status(in_status),
    .in_data(in_data), .in_pos(in_pos),
    .an(an0), .seg(seg0), .err(err0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] an;
    logic [7:0] s1;
    logic [7:0] s0;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  int   m_shadow [8];
  int   m_frame  [8];
  bit   m_err;
  int   m_prev;
  int   m_cyc;

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic logic [7:0] exp_digit(input int k, input bit lz);
    bit above_zero;
    if (m_err) begin
      if (k == 2) return 8'h86;
      if (k < 2) return 8'hAF;
      return 8'hFF;
    end
    above_zero = 1;
    for (int j = k; j < 8; j++)
      if (m_frame[j] != 0) above_zero = 0;
    if (lz && k != 0 && above_zero) return 8'hFF;
    if (m_frame[k] > 9) return 8'hFF;
    return seg_tab[m_frame[k]];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_shadow[i] = 0;
      m_frame[i]  = 0;
    end
    m_err  = 0;
    m_prev = 1;
    m_cyc  = 0;
  endtask

  // Called at a negedge; the predicted response is for the next posedge
  task automatic step(input int st, input int p, input int d);
    exp_t e;
    int   s;
    in_status = 2'(st);
    in_pos    = 4'(p);
    in_data   = 4'(d);
    s    = (m_cyc / RDIV) % 8;
    e.an = ~(8'd1 << s);
    e.s1 = exp_digit(s, 1);
    e.s0 = exp_digit(s, 0);
    if (st == 0) m_err = 1;
    if (!m_err) begin
      if (st == 1 && p < 8) m_shadow[p] = d;
      if (m_prev == 1 && st == 2) m_frame = m_shadow;
    end
    m_prev = st;
    m_cyc++;
    e.err = m_err;
    q.push_back(e);
    @(negedge clock);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_an", an1, 8'hFF);
    chk("rst_seg", seg1, 8'hFF);
    chk("rst_seg_nolz", seg0, 8'hFF);
    chk("rst_err", {7'd0, err1}, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic hold_ready(input int n);
    for (int i = 0; i < n; i++)
      step(2, $urandom_range(0, 15), $urandom_range(0, 15));
  endtask

  task automatic write_frame(input int v [8]);
    for (int i = 0; i < 8; i++) step(1, i, v[i]);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("an", an1, e.an);
        chk("an_nolz", an0, e.an);
        chk("seg", seg1, e.s1);
        chk("seg_nolz", seg0, e.s0);
        chk("err", {7'd0, err1}, {7'd0, e.err});
      end
    end
  end

  initial begin : stim
    int v [8];
    int top;
    reset     = 1'b1;
    in_status = 2'b01;
    in_pos    = 4'd0;
    in_data   = 4'd0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    do_reset();

    v = '{4, 3, 2, 1, 0, 0, 0, 0};
    write_frame(v);
    hold_ready(40);

    step(1, 0, 7);
    hold_ready(40);

    v = '{0, 0, 0, 0, 0, 0, 0, 0};
    write_frame(v);
    hold_ready(36);

    step(1, 9, 5);
    step(1, 15, 3);
    step(3, 0, 6);
    step(2, 0, 6);
    hold_ready(34);

    for (int f = 0; f < 25; f++) begin
      top = $urandom_range(0, 7);
      for (int i = 0, n = $urandom_range(1, 12); i < n; i++) begin
        if ($urandom_range(0, 5) == 0)
          step(1, $urandom_range(0, 15), $urandom_range(0, 15));
        else
          step(1, $urandom_range(0, top), $urandom_range(0, 9));
      end
      if ($urandom_range(0, 4) == 0) step(3, 0, 0);
      hold_ready($urandom_range(34, 40));
    end

    step(1, 0, 5);
    step(1, 1, 6);
    step(0, 2, 7);
    step(1, 3, 8);
    step(2, 0, 0);
    hold_ready(36);
    step(1, 0, 1);
    step(2, 0, 0);
    hold_ready(34);

    repeat (5) step(2, 0, 0);
    do_reset();
    step(1, 1, 9);
    step(2, 0, 0);
    hold_ready(36);

    repeat (3) @(posedge clock);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
